condicionador_entradas: RTL

Input conditioner placed directly upstream of the drone simulator top level. It takes the three raw, asynchronous push-button levels from the board, synchronises and debounces them, and produces two outputs:
- the 2-bit `controle` command level consumed by the simulator;
- a single-cycle `iniciar` pulse on each press of the start button.

It also exports the debounced button levels for debug displays.

---
 rtl/condicionador_entradas.sv | 134 +++++++++++++
 1 files changed

// File: rtl/condicionador_entradas.sv
// condicionador_entradas
//   Input conditioner in front of the drone simulator. The three raw push
//   buttons are synchronised (two flops each) and then debounced. The
//   debounced levels drive the 2-bit command, a start pulse and a debug bus.
//
//   Build option: CONDICIONADOR_DEBOUNCE_EN
//     defined   - per-channel debounce FSM + counter (DEBOUNCE_CICLOS stable
//                 cycles required before a level change)
//     undefined - debounce bypassed, nivel follows s2 every cycle
//
//   Ports:
//     clock          system clock, rising edge
//     reset          asynchronous, active-high; clears all state
//     botao_subir    raw "up" button
//     botao_descer   raw "down" button
//     botao_iniciar  raw start button
//     controle       2'b01 up, 2'b10 down, 2'b00 none (or both)
//     iniciar        one-cycle pulse on debounced press of start
//     db_botoes      debounced levels {iniciar, descer, subir}
module condicionador_entradas #(
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int CONT_W          = $clog2(DEBOUNCE_CICLOS) + 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       botao_subir,
   input  logic       botao_descer,
   input  logic       botao_iniciar,
   output logic [1:0] controle,
   output logic       iniciar,
   output logic [2:0] db_botoes
);

   logic [2:0] bruto;
   logic [2:0] s1;
   logic [2:0] s2;
   logic [2:0] nivel;
   logic       nivel_ini_ant;

   // channel order matches db_botoes: {iniciar, descer, subir}
   assign bruto = {botao_iniciar, botao_descer, botao_subir};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= bruto;
         s2 <= s1;
      end
   end

`ifdef CONDICIONADOR_DEBOUNCE_EN
   typedef enum logic {ESTAVEL, CONTANDO} estado_t;

   localparam logic [CONT_W-1:0] LIMITE = CONT_W'(DEBOUNCE_CICLOS - 1);

   for (genvar i = 0; i < 3; i++) begin : g_canal
      logic nivel_c;

      if (DEBOUNCE_CICLOS == 1) begin : g_direto
         // one stable sample is enough: no counting state needed
         always_ff @(posedge clock or posedge reset) begin
            if (reset) nivel_c <= 1'b0;
            else       nivel_c <= s2[i];
         end
      end else begin : g_fsm
         estado_t           estado;
         logic [CONT_W-1:0] cont;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               estado  <= ESTAVEL;
               cont    <= '0;
               nivel_c <= 1'b0;
            end else begin
               case (estado)
                  ESTAVEL: begin
                     cont <= '0;
                     if (s2[i] != nivel_c) begin
                        estado <= CONTANDO;
                        cont   <= CONT_W'(1);
                     end
                  end
                  CONTANDO: begin
                     if (s2[i] == nivel_c) begin
                        // bounce back to the old level: discard and restart
                        estado <= ESTAVEL;
                        cont   <= '0;
                     end else if (cont == LIMITE) begin
                        nivel_c <= s2[i];
                        cont    <= '0;
                        estado  <= ESTAVEL;
                     end else begin
                        cont <= cont + CONT_W'(1);
                     end
                  end
                  default: begin
                     estado <= ESTAVEL;
                     cont   <= '0;
                  end
               endcase
            end
         end
      end

      assign nivel[i] = nivel_c;
   end
`else
   always_ff @(posedge clock or posedge reset) begin
      if (reset) nivel <= '0;
      else       nivel <= s2;
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         nivel_ini_ant <= 1'b0;
         iniciar       <= 1'b0;
      end else begin
         nivel_ini_ant <= nivel[2];
         iniciar       <= nivel[2] & ~nivel_ini_ant;
      end
   end

   // both directions pressed at once is treated as no command
   always_comb begin
      controle = 2'b00;
      if (nivel[0] ^ nivel[1]) controle = {nivel[1], nivel[0]};
   end

   assign db_botoes = nivel;

endmodule
